// File: rtl/aes_pkg.sv
// aes_pkg: shared AES arithmetic for the round pipe.
// Byte n of a state lives at bits [127-8n -: 8] (column-major, FIPS-197).
// S-boxes are computed from GF(2^8) inversion plus the affine map, so there are no tables.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int COL_W   = 32;
  localparam int STATE_W = 128;

  function automatic logic [3:0] nr(input int key_bits);
    case (key_bits)
      192:     return 4'd12;
      256:     return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [STATE_W-1:0] sub_bytes(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[STATE_W-1-BYTE_W*n -: BYTE_W] = sbox(s[STATE_W-1-BYTE_W*n -: BYTE_W]);
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] inv_sub_bytes(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[STATE_W-1-BYTE_W*n -: BYTE_W] = inv_sbox(s[STATE_W-1-BYTE_W*n -: BYTE_W]);
    return r;
  endfunction

  // row r rotates left by r columns
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[STATE_W-1-BYTE_W*(w+4*c) -: BYTE_W] = s[STATE_W-1-BYTE_W*(w+4*((c+w)%4)) -: BYTE_W];
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[STATE_W-1-BYTE_W*(w+4*c) -: BYTE_W] = s[STATE_W-1-BYTE_W*(w+4*((c+4-w)%4)) -: BYTE_W];
    return r;
  endfunction

  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [STATE_W-1:0] mix_columns(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[STATE_W-1-COL_W*c -: COL_W] = mix_col(s[STATE_W-1-COL_W*c -: COL_W]);
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] inv_mix_columns(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[STATE_W-1-COL_W*c -: COL_W] = inv_mix_col(s[STATE_W-1-COL_W*c -: COL_W]);
    return r;
  endfunction

  // First half of a round; last = this is round NR (no (Inv)MixColumns)
  function automatic logic [STATE_W-1:0] round_front(input logic [STATE_W-1:0] s,
      input logic [STATE_W-1:0] k, input logic enc, input logic last);
    if (enc) return shift_rows(sub_bytes(s));
    return last ? (s ^ k) : inv_mix_columns(s ^ k);
  endfunction

  // Second half of a round
  function automatic logic [STATE_W-1:0] round_back(input logic [STATE_W-1:0] s,
      input logic [STATE_W-1:0] k, input logic enc, input logic last);
    if (enc) return (last ? s : mix_columns(s)) ^ k;
    return inv_sub_bytes(inv_shift_rows(s));
  endfunction

endpackage

// File: rtl/aes_pipe_slice.sv
// aes_pipe_slice: one valid/payload register slice with skid-free pass-through ready.
module aes_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         adv;

  // the held beat leaves this edge, so a new one may take its place
  assign adv      = valid_reg && out_ready;
  assign in_ready = !valid_reg || adv;

  // occupancy: only the valid bit is reset
  always_ff @(posedge clk) begin
    if (reset) valid_reg <= 1'b0;
    else if (in_ready) valid_reg <= in_valid;
  end

  // payload capture on an accepted beat
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) data_reg <= in_data;
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/aes_round_pipe.sv
// aes_round_pipe: one AES round per beat, forward or inverse, valid/ready pipelined.
// Front half of the round sits before slice 0, back half before the last slice.
// Optional feature macro: AES_RND_PERF_EN adds perf_beats / perf_stalls counters.
module aes_round_pipe
  import aes_pkg::*;
#(
  parameter int KEY_BITS   = 128,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic [3:0]       in_round,
  input  logic             in_encrypt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [3:0]       out_round,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef AES_RND_PERF_EN
  ,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stalls
`endif
);

  localparam logic [3:0] NR = nr(KEY_BITS);
  localparam int LAST    = PIPE_DEPTH - 1;
  // beat layout: {err, encrypt, round, tag, key, data}
  localparam int KEY_LSB = STATE_W;
  localparam int TAG_LSB = 2 * STATE_W;
  localparam int RND_LSB = TAG_LSB + TAG_W;
  localparam int ENC_BIT = RND_LSB + 4;
  localparam int ERR_BIT = ENC_BIT + 1;
  localparam int PW      = ERR_BIT + 1;

  logic               in_err;
  logic [STATE_W-1:0] front_data;
  logic [PW-1:0]      front_beat;
  logic [PW-1:0]      out_beat;
  logic               unused_tail;

  // front half of the round; illegal rounds pass the state through flagged
  always_comb begin
    in_err     = (in_round == 4'd0) || (in_round > NR);
    front_data = in_err ? in_data
                        : round_front(in_data, in_key, in_encrypt, in_round == NR);
    front_beat = {in_err, in_encrypt, in_round, in_tag, in_key, front_data};
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slice
      logic          up_valid;
      logic          up_ready;
      logic [PW-1:0] up_beat;
      logic          dn_valid;
      logic          dn_ready;
      logic [PW-1:0] dn_beat;

      if (gi == 0) begin : g_first
        assign up_valid = in_valid;
        assign up_beat  = front_beat;
      end else if (gi == LAST) begin : g_back
        logic [PW-1:0]      prev;
        logic [STATE_W-1:0] back_data;
        assign prev = g_slice[gi-1].dn_beat;
        // back half of the round on the beat leaving the previous slice
        always_comb begin
          back_data = prev[ERR_BIT] ? prev[STATE_W-1:0]
                    : round_back(prev[STATE_W-1:0], prev[KEY_LSB +: STATE_W],
                                 prev[ENC_BIT], prev[RND_LSB +: 4] == NR);
        end
        assign up_valid = g_slice[gi-1].dn_valid;
        assign up_beat  = {prev[PW-1:STATE_W], back_data};
      end else begin : g_delay
        assign up_valid = g_slice[gi-1].dn_valid;
        assign up_beat  = g_slice[gi-1].dn_beat;
      end

      if (gi == LAST) begin : g_tail
        assign dn_ready = out_ready;
      end else begin : g_link
        assign dn_ready = g_slice[gi+1].up_ready;
      end

      aes_pipe_slice #(.W(PW)) u_slice (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (up_valid),
        .in_ready  (up_ready),
        .in_data   (up_beat),
        .out_valid (dn_valid),
        .out_ready (dn_ready),
        .out_data  (dn_beat)
      );
    end
  endgenerate

  assign in_ready    = g_slice[0].up_ready;
  assign out_valid   = g_slice[LAST].dn_valid;
  assign out_beat    = g_slice[LAST].dn_beat;
  assign out_data    = out_beat[STATE_W-1:0];
  assign out_tag     = out_beat[TAG_LSB +: TAG_W];
  assign out_round   = out_beat[RND_LSB +: 4];
  assign out_err     = out_valid && out_beat[ERR_BIT];
  // key and mode are consumed by the back half, not by the output
  assign unused_tail = ^{out_beat[KEY_LSB +: STATE_W], out_beat[ENC_BIT]};

`ifdef AES_RND_PERF_EN
  // output transfer and stall counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beats  <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      if (out_valid && out_ready)  perf_beats  <= perf_beats + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: directed FIPS-197 round vectors, scoreboard plus negedge monitor.
module tb_aes_round_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [127:0]     in_key;
  logic [3:0]       in_round;
  logic             in_encrypt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [3:0]       out_round;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
`ifdef AES_RND_PERF_EN
  logic [31:0]      perf_beats;
  logic [31:0]      perf_stalls;
`endif

  aes_round_pipe #(.KEY_BITS(128), .PIPE_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
    .in_round   (in_round),
    .in_encrypt (in_encrypt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_round  (out_round),
    .out_tag    (out_tag),
    .out_err    (out_err)
`ifdef AES_RND_PERF_EN
    ,
    .perf_beats (perf_beats),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0]     data;
    logic [3:0]       round;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             exact;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pops = 0;
  int stalls_seen = 0;
  int rdy_mode = 0;
  logic [127:0] cur_exp_data;
  logic         cur_exp_err;
  logic         exact_lat;

  // hand-computed FIPS-197 Appendix B round vectors: in, key, round, encrypt, expected
  logic [127:0] v_in  [4];
  logic [127:0] v_key [4];
  logic [3:0]   v_rnd [4];
  logic         v_enc [4];
  logic [127:0] v_exp [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // downstream ready: always, 1-0-0 pattern, or held off
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      ph++;
    end
  end

  // monitor: in_ready rule, stall stability, scoreboard pop and push
  initial begin
    logic         stall_prev;
    logic [127:0] hold_d;
    logic [3:0]   hold_r;
    logic [TAG_W-1:0] hold_t;
    logic         hold_e;
    exp_t         e;
    stall_prev = 1'b0;
    hold_d = '0; hold_r = '0; hold_t = '0; hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        stall_prev  = 1'b0;
        stalls_seen = 0;
      end else begin
        chk("in_ready", {127'd0, in_ready},
            {127'd0, !(sb.size() == DEPTH && !out_ready)});
        if (stall_prev) begin
          chk("stall_valid", {127'd0, out_valid}, 128'd1);
          chk("stall_data", out_data, hold_d);
          chk("stall_meta", {119'd0, out_round, out_tag, out_err},
              {119'd0, hold_r, hold_t, hold_e});
        end
        if (!out_valid) chk("idle_err", {127'd0, out_err}, 128'd0);
        if (out_valid && sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual=valid required=idle data=%h", out_data);
        end else if (out_valid && out_ready) begin
          e = sb.pop_front();
          pops++;
          $display("beat tag=%0d round=%0d err=%0b data=%h lat=%0d",
                   out_tag, out_round, out_err, out_data, cyc - e.acc_cyc);
          chk("out_data", out_data, e.data);
          chk("out_tag", {124'd0, out_tag}, {124'd0, e.tag});
          chk("out_round", {124'd0, out_round}, {124'd0, e.round});
          chk("out_err", {127'd0, out_err}, {127'd0, e.err});
          if (e.exact) chk("latency", 128'(cyc - e.acc_cyc), 128'(DEPTH));
          else         chk("latency_min", {127'd0, (cyc - e.acc_cyc) >= DEPTH}, 128'd1);
        end
        stall_prev = out_valid && !out_ready;
        if (stall_prev) stalls_seen++;
        hold_d = out_data; hold_r = out_round; hold_t = out_tag; hold_e = out_err;
        if (in_valid && in_ready) begin
          e.data    = cur_exp_data;
          e.round   = in_round;
          e.tag     = in_tag;
          e.err     = cur_exp_err;
          e.exact   = exact_lat;
          e.acc_cyc = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [3:0] r,
                      input logic enc, input logic [TAG_W-1:0] tag,
                      input logic [127:0] exp_d, input logic exp_e);
    logic acc;
    in_data = d; in_key = k; in_round = r; in_encrypt = enc; in_tag = tag;
    cur_exp_data = exp_d; cur_exp_err = exp_e;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", tag);
    end
  endtask

  task automatic send_vec(input int i, input logic [TAG_W-1:0] tag);
    send(v_in[i], v_key[i], v_rnd[i], v_enc[i], tag, v_exp[i], 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) @(posedge clk);
    chk("drain", 128'(sb.size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int p0;
    v_in[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; v_key[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    v_rnd[0] = 4'd1;  v_enc[0] = 1'b1; v_exp[0] = 128'ha49c7ff2689f352b6b5bea43026a5049;
    v_in[1] = 128'heb40f21e592e38848ba113e71bc342d2; v_key[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    v_rnd[1] = 4'd10; v_enc[1] = 1'b1; v_exp[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    v_in[2] = 128'h3925841d02dc09fbdc118597196a0b32; v_key[2] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    v_rnd[2] = 4'd10; v_enc[2] = 1'b0; v_exp[2] = 128'heb40f21e592e38848ba113e71bc342d2;
    v_in[3] = 128'ha49c7ff2689f352b6b5bea43026a5049; v_key[3] = 128'ha0fafe1788542cb123a339392a6c7605;
    v_rnd[3] = 4'd1;  v_enc[3] = 1'b0; v_exp[3] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_round = '0;
    in_encrypt = 1'b0; in_tag = '0; cur_exp_data = '0; cur_exp_err = 1'b0; exact_lat = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_err", {127'd0, out_err}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // encrypt round 1, encrypt round 10, then their inverses
    send_vec(0, 4'd1);
    drain();
    send_vec(1, 4'd2);
    drain();
    send_vec(2, 4'd3);
    send_vec(3, 4'd4);
    drain();

    // illegal rounds pass through flagged; the following legal beat is clean
    send(v_in[0], v_key[0], 4'd0,  1'b1, 4'd5, v_in[0], 1'b1);
    send(v_in[1], v_key[1], 4'd11, 1'b0, 4'd5, v_in[1], 1'b1);
    send_vec(1, 4'd6);
    drain();

    // counters restart from reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef AES_RND_PERF_EN
    chk("perf_beats_rst", {96'd0, perf_beats}, 128'd0);
    chk("perf_stalls_rst", {96'd0, perf_stalls}, 128'd0);
`endif

    // eight back-to-back beats under a 1,0,0 out_ready pattern
    exact_lat = 1'b0;
    rdy_mode = 1;
    p0 = pops;
    for (int i = 0; i < 8; i++) send_vec(i % 4, 4'(i));
    drain();
    rdy_mode = 0;
    chk("bp_count", 128'(pops - p0), 128'd8);
`ifdef AES_RND_PERF_EN
    chk("perf_beats", {96'd0, perf_beats}, 128'd8);
    chk("perf_stalls", {96'd0, perf_stalls}, 128'(stalls_seen));
`endif

    // reset with two beats held in flight
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_vec(0, 4'd7);
    send_vec(3, 4'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_out_err", {127'd0, out_err}, 128'd0);
    reset = 1'b0;
    rdy_mode = 0;
    p0 = pops;
    send_vec(2, 4'd9);
    drain();
    chk("midrst_pops", 128'(pops - p0), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
